// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light phase sequencer with per-phase second countdowns,
// night blink mode and pedestrian shortening of road-1 green.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 7,
    parameter int MIN_GREEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1s,
    input  logic             night,
    input  logic [CNT_W-1:0] green1_time,
    input  logic [CNT_W-1:0] green2_time,
    input  logic [CNT_W-1:0] yellow_time,
    input  logic             ped_req,
    output logic             ped_pending,
    output logic [5:0]       lights,
    output logic [CNT_W-1:0] remain1,
    output logic [CNT_W-1:0] remain2,
    output logic [2:0]       phase,
    output logic             phase_start
);

    typedef enum logic [2:0] {
        NIGHT = 3'd0,
        G1    = 3'd1,
        Y1    = 3'd2,
        G2    = 3'd3,
        Y2    = 3'd4
    } phase_t;

    localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic             ped_q, ped_d;
    logic             start_q, start_d;
    logic             ped_acc;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sum_sat;

    // A zero duration would never reach the cnt==1 advance point.
    function automatic logic [CNT_W-1:0] load(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= NIGHT;
            cnt_q   <= '0;
            blink_q <= 1'b1;
            ped_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            ped_q   <= ped_d;
            start_q <= start_d;
        end
    end

    assign ped_acc = ped_req && (phase_q inside {G1, Y1, Y2});

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        ped_d   = ped_q;
        start_d = 1'b0;
        if (phase_q == NIGHT) begin
            if (!night) begin
                phase_d = G1;
                cnt_d   = load(green1_time);
                start_d = 1'b1;
            end else if (tick_1s) begin
                blink_d = ~blink_q;
            end
        end else if (night) begin
            phase_d = NIGHT;
            cnt_d   = '0;
            ped_d   = 1'b0;
            blink_d = 1'b1;
        end else begin
            if (ped_acc)
                ped_d = 1'b1;
            if (tick_1s && cnt_q <= CNT_W'(1)) begin
                start_d = 1'b1;
                unique case (phase_q)
                    G1: begin
                        phase_d = Y1;
                        cnt_d   = load(yellow_time);
                    end
                    Y1: begin
                        phase_d = G2;
                        cnt_d   = load(green2_time);
                        ped_d   = 1'b0;
                    end
                    G2: begin
                        phase_d = Y2;
                        cnt_d   = load(yellow_time);
                    end
                    default: begin
                        phase_d = G1;
                        cnt_d   = load(green1_time);
                    end
                endcase
            end else if (phase_q == G1 && (ped_q || ped_acc)
                         && cnt_q > MIN_G) begin
                // cnt only falls within G1, so this fires at most once.
                cnt_d = MIN_G;
            end else if (tick_1s) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign sum     = {1'b0, cnt_q} + {1'b0, yellow_time};
    assign sum_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

    always_comb begin
        lights  = {1'b0, blink_q, 1'b0, 1'b0, blink_q, 1'b0};
        remain1 = '0;
        remain2 = '0;
        unique case (phase_q)
            G1: begin
                lights  = 6'b001100;
                remain1 = cnt_q;
                remain2 = sum_sat;
            end
            Y1: begin
                lights  = 6'b010100;
                remain1 = cnt_q;
                remain2 = cnt_q;
            end
            G2: begin
                lights  = 6'b100001;
                remain1 = sum_sat;
                remain2 = cnt_q;
            end
            Y2: begin
                lights  = 6'b100010;
                remain1 = cnt_q;
                remain2 = cnt_q;
            end
            default: ;
        endcase
    end

    assign phase       = phase_q;
    assign phase_start = start_q;
    assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomized bench for traffic_phase_scheduler against a
// table-driven reference model of the phase sequence.
module tb_traffic_phase_scheduler;

    localparam int W  = 7;
    localparam int MG = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_1s;
    logic         night;
    logic [W-1:0] green1_time;
    logic [W-1:0] green2_time;
    logic [W-1:0] yellow_time;
    logic         ped_req;
    logic         ped_pending;
    logic [5:0]   lights;
    logic [W-1:0] remain1;
    logic [W-1:0] remain2;
    logic [2:0]   phase;
    logic         phase_start;

    traffic_phase_scheduler #(.CNT_W(W), .MIN_GREEN(MG)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1s     (tick_1s),
        .night       (night),
        .green1_time (green1_time),
        .green2_time (green2_time),
        .yellow_time (yellow_time),
        .ped_req     (ped_req),
        .ped_pending (ped_pending),
        .lights      (lights),
        .remain1     (remain1),
        .remain2     (remain2),
        .phase       (phase),
        .phase_start (phase_start)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: phase index 0..4, seconds left in the phase.
    int m_ph, m_left, m_blink, m_ped, m_start;
    int lamp_tab [5] = '{0, 'b001100, 'b010100, 'b100001, 'b100010};

    function automatic int ld(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int dur(input int p);
        if (p == 1) return ld(int'(green1_time));
        if (p == 3) return ld(int'(green2_time));
        return ld(int'(yellow_time));
    endfunction

    function automatic int sat(input int v);
        return (v > 127) ? 127 : v;
    endfunction

    task automatic model_step();
        int np;
        m_start = 0;
        if (rst) begin
            m_ph = 0; m_left = 0; m_blink = 1; m_ped = 0;
            return;
        end
        if (m_ph == 0) begin
            if (!night) begin
                m_ph = 1; m_left = dur(1); m_start = 1;
            end else if (tick_1s) begin
                m_blink = 1 - m_blink;
            end
            return;
        end
        if (night) begin
            m_ph = 0; m_left = 0; m_ped = 0; m_blink = 1;
            return;
        end
        if (ped_req && m_ph != 3) m_ped = 1;
        if (tick_1s && m_left == 1) begin
            np = (m_ph % 4) + 1;
            m_left = dur(np);
            if (np == 3) m_ped = 0;
            m_ph = np;
            m_start = 1;
        end else if (m_ph == 1 && m_ped == 1 && m_left > MG) begin
            m_left = MG;
        end else if (tick_1s) begin
            m_left = m_left - 1;
        end
    endtask

    task automatic check_all();
        int el, r1, r2, y;
        y  = int'(yellow_time);
        el = (m_ph == 0) ? (m_blink ? 'b010010 : 0) : lamp_tab[m_ph];
        r1 = 0;
        r2 = 0;
        case (m_ph)
            1: begin r1 = m_left; r2 = sat(m_left + y); end
            3: begin r2 = m_left; r1 = sat(m_left + y); end
            2, 4: begin r1 = m_left; r2 = m_left; end
            default: ;
        endcase
        chk("phase", 32'(phase), m_ph);
        chk("lights", 32'(lights), el);
        chk("remain1", 32'(remain1), r1);
        chk("remain2", 32'(remain2), r2);
        chk("ped_pending", 32'(ped_pending), m_ped);
        chk("phase_start", 32'(phase_start), m_start);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [W-1:0] pick_dur();
        if ($urandom_range(0, 4) == 0) return '0;
        if ($urandom_range(0, 9) == 0) return W'($urandom_range(100, 127));
        return W'($urandom_range(1, 12));
    endfunction

    initial begin
        int period, tdiv;
        rst = 1'b1; night = 1'b0; tick_1s = 1'b0; ped_req = 1'b0;
        green1_time = 7; green2_time = 7; yellow_time = 5;
        m_ph = 0; m_left = 0; m_blink = 1; m_ped = 0; m_start = 0;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick_1s = (i % 10 == 9);
            ped_req = (i == 95 || i == 185 || i == 255);
            step();
        end
        ped_req = 1'b0;
        green1_time = 9;
        night = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick_1s = (i % 10 == 9);
            step();
        end
        night = 1'b0;
        green1_time = 0;
        for (int i = 0; i < 60; i++) begin
            tick_1s = (i % 10 == 9);
            step();
        end
        period = 1;
        tdiv = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i % 1000 == 0) period = $urandom_range(1, 5);
            tick_1s = (tdiv == 0);
            tdiv = (tdiv + 1) % period;
            if ($urandom_range(0, 49) == 0) green1_time = pick_dur();
            if ($urandom_range(0, 49) == 0) green2_time = pick_dur();
            if ($urandom_range(0, 49) == 0) yellow_time = pick_dur();
            if (night) night = ($urandom_range(0, 39) != 0);
            else night = ($urandom_range(0, 599) == 0);
            rst = ($urandom_range(0, 1999) == 0);
            ped_req = ($urandom_range(0, 29) == 0);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
